// File: rtl/loader_pkg.sv
// Shared types for the UART program-image loader: FSM state encoding,
// default frame marker and the running checksum helper.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN0,
        LEN1,
        BYTES,
        CHECK,
        DONE,
        ERR
    } state_e;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // Modulo-256 running sum used for the frame checksum.
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Byte-in / word-out bus of the loader: UART receive strobe on one side,
// instruction-memory write port on the other.
interface imem_uart_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [3:0]        imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    // Loader side: consumes UART bytes, produces memory writes.
    modport master (
        input  rx_data,
        input  rx_valid,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

    // Environment side: UART receiver and instruction memory.
    modport slave (
        output rx_data,
        output rx_valid,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );
endinterface

// File: rtl/byte_word_packer.sv
// Packs frame body bytes LSB-first into 32-bit words and keeps the
// modulo-256 checksum of every byte packed since the last clear.
module byte_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        vld_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o,
    output logic [7:0]  chksum_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shreg_q, shreg_d;
    logic [7:0]  sum_q, sum_d;

    // Next byte slot, partial word and checksum; clear wins over a byte.
    always_comb begin
        idx_d   = idx_q;
        shreg_d = shreg_q;
        sum_d   = sum_q;
        if (clr_i) begin
            idx_d   = '0;
            shreg_d = '0;
            sum_d   = '0;
        end else if (vld_i) begin
            // Index wraps from 3 back to 0, starting the next word.
            idx_d = idx_q + 2'd1;
            sum_d = chk_add(sum_q, byte_i);
            case (idx_q)
                2'd0:    shreg_d[7:0]   = byte_i;
                2'd1:    shreg_d[15:8]  = byte_i;
                2'd2:    shreg_d[23:16] = byte_i;
                default: shreg_d        = shreg_q;
            endcase
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            shreg_q <= '0;
            sum_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            sum_q   <= sum_d;
        end
    end

    // The fourth byte completes the word in the same cycle it arrives, so the
    // top level can register the write one cycle after that strobe.
    assign word_done_o = vld_i & ~clr_i & (idx_q == 2'd3);
    assign word_o      = {byte_i, shreg_q};
    assign chksum_o    = sum_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Frames UART bytes into a program image and writes it word-by-word into
// instruction memory, holding fetch in restart for the whole load.
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MAX_WORDS   = 4096,
    parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic                prog_req,
    imem_uart_loader_if.master  bus,
    output logic                memcon_prog_ena,
    output logic                state_load_prog,
    output logic                load_done,
    output logic                load_err
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic              prog_prev_q;
    logic [15:0]       len_q, len_d;
    logic [15:0]       widx_q, widx_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              memcon_q, memcon_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [3:0]        we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              prog_rise;
    logic [15:0]       len_full;
    logic              last_word;
    logic              tmo_hit;
    logic              frame_active;
    logic              pk_clr;
    logic              pk_vld;
    logic              word_done;
    logic [31:0]       pk_word;
    logic [7:0]        pk_sum;

    assign rx_valid     = bus.rx_valid;
    assign rx_data      = bus.rx_data;
    // Only a fresh request starts a load; a level left high after a frame does not.
    assign prog_rise    = prog_req & ~prog_prev_q;
    assign len_full     = {rx_data, len_q[7:0]};
    assign last_word    = (widx_q == (len_q - 16'd1));
    assign tmo_hit      = (tmo_q == TMO_LAST);
    assign frame_active = (state_q == LEN0) || (state_q == LEN1) ||
                          (state_q == BYTES) || (state_q == CHECK);
    assign pk_clr       = (state_q == LEN1);
    assign pk_vld       = (state_q == BYTES) && rx_valid;

    byte_word_packer u_packer (
        .clk         (clk),
        .rst         (Rst),
        .clr_i       (pk_clr),
        .vld_i       (pk_vld),
        .byte_i      (rx_data),
        .word_done_o (word_done),
        .word_o      (pk_word),
        .chksum_o    (pk_sum)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a received byte always takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (prog_rise) state_d = SYNC;
            end
            SYNC: begin
                if (!prog_req)                              state_d = IDLE;
                else if (rx_valid && (rx_data == SYNC_BYTE)) state_d = LEN0;
            end
            LEN0: begin
                if (rx_valid)     state_d = LEN1;
                else if (tmo_hit) state_d = ERR;
            end
            LEN1: begin
                if (rx_valid) begin
                    if (32'(len_full) > MAX_WORDS) state_d = ERR;
                    else if (len_full == 16'd0)    state_d = CHECK;
                    else                           state_d = BYTES;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            BYTES: begin
                if (word_done && last_word)  state_d = CHECK;
                else if (!rx_valid && tmo_hit) state_d = ERR;
            end
            CHECK: begin
                if (rx_valid)     state_d = (rx_data == pk_sum) ? DONE : ERR;
                else if (tmo_hit) state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state: length capture, timeout, write register, status flags.
    always_comb begin
        len_d    = len_q;
        widx_d   = widx_q;
        tmo_d    = '0;
        memcon_d = memcon_q;
        done_d   = done_q;
        err_d    = err_q;
        we_d     = 4'h0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        // Idle-byte counter only runs inside a frame; any byte restarts it.
        if (frame_active && !rx_valid) tmo_d = tmo_q + 32'd1;

        if ((state_q == LEN0) && rx_valid) len_d[7:0] = rx_data;
        if ((state_q == LEN1) && rx_valid) begin
            len_d  = len_full;
            widx_d = '0;
        end

        // Completed word is written exactly once, on the cycle after its last byte.
        if (word_done) begin
            we_d    = 4'hF;
            waddr_d = ADDR_W'({widx_q, 2'b00});
            wdata_d = pk_word;
            widx_d  = widx_q + 16'd1;
        end

        if ((state_q == IDLE) && (state_d == SYNC)) begin
            memcon_d = 1'b1;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end
        if ((state_q != IDLE) && (state_d == IDLE)) memcon_d = 1'b0;
        if ((state_q != DONE) && (state_d == DONE)) done_d   = 1'b1;
        if ((state_q != ERR)  && (state_d == ERR))  err_d    = 1'b1;
    end

    // Datapath and status registers; reset drops any pending write immediately.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            prog_prev_q <= 1'b0;
            len_q       <= '0;
            widx_q      <= '0;
            tmo_q       <= '0;
            memcon_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 4'h0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            prog_prev_q <= prog_req;
            len_q       <= len_d;
            widx_q      <= widx_d;
            tmo_q       <= tmo_d;
            memcon_q    <= memcon_d;
            done_q      <= done_d;
            err_q       <= err_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.imem_we      = we_q;
    assign bus.imem_waddr   = waddr_q;
    assign bus.imem_wdata   = wdata_q;
    assign memcon_prog_ena  = memcon_q;
    assign state_load_prog  = (state_q == BYTES) || (state_q == CHECK);
    assign load_done        = done_q;
    assign load_err         = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: byte-level frame stimulus with a write scoreboard.
module tb_imem_uart_loader;

    localparam int unsigned ADDR_W = 32;

    logic clk;
    logic Rst;
    logic prog_req;
    logic memcon_prog_ena;
    logic state_load_prog;
    logic load_done;
    logic load_err;

    imem_uart_loader_if #(.ADDR_W(ADDR_W)) ifc ();

    imem_uart_loader #(
        .ADDR_W      (ADDR_W),
        .MAX_WORDS   (4096),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk             (clk),
        .Rst             (Rst),
        .prog_req        (prog_req),
        .bus             (ifc.master),
        .memcon_prog_ena (memcon_prog_ena),
        .state_load_prog (state_load_prog),
        .load_done       (load_done),
        .load_err        (load_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    int         tests_run;
    int         tests_failed;
    int         wr_seen;
    int         cyc;
    logic [7:0] chk_acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write seen must match the next expected one, including cycle.
    always @(negedge clk) begin
        if (ifc.imem_we !== 4'h0) begin
            wr_t e;
            wr_seen   = wr_seen + 1;
            tests_run = tests_run + 1;
            if (exp_q.size() == 0) begin
                tests_failed = tests_failed + 1;
                $display("FAIL unexpected_write: got we=%h addr=%h data=%h, expected no write",
                         ifc.imem_we, ifc.imem_waddr, ifc.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (ifc.imem_we !== 4'hF || ifc.imem_waddr !== e.addr ||
                    ifc.imem_wdata !== e.data || cyc != e.cyc) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL write: got we=%h addr=%h data=%h cyc=%0d, expected we=f addr=%h data=%h cyc=%0d",
                             ifc.imem_we, ifc.imem_waddr, ifc.imem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        @(negedge clk);
        ifc.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx);
        logic [7:0] b;
        wr_t        e;
        for (int k = 0; k < 4; k++) begin
            b       = w[8*k +: 8];
            chk_acc = chk_acc + b;
            if (k == 3) begin
                e.addr = 32'(idx) << 2;
                e.data = w;
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
            send_byte(b, 0);
        end
    endtask

    task automatic start_req();
        prog_req = 1'b0;
        repeat (2) @(negedge clk);
        prog_req = 1'b1;
        @(negedge clk);
        chk_acc = 8'h00;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        prog_req = 1'b0;
        ifc.rx_valid = 1'b0;
        ifc.rx_data = 8'h00;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({memcon_prog_ena, state_load_prog, load_done, load_err} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 0000",
                     {memcon_prog_ena, state_load_prog, load_done, load_err});
        end
        tests_run++;
        if (ifc.imem_we !== 4'h0 || ifc.imem_waddr !== 32'h0 || ifc.imem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: got we=%h addr=%h data=%h, expected all 0",
                     ifc.imem_we, ifc.imem_waddr, ifc.imem_wdata);
        end
        Rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_normal_load();
        int wr0;
        wr0 = wr_seen;
        start_req();
        tests_run++;
        if (memcon_prog_ena !== 1'b1) begin
            tests_failed++;
            $display("FAIL normal_memcon_set: got %b, expected 1", memcon_prog_ena);
        end
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        tests_run++;
        if (state_load_prog !== 1'b1) begin
            tests_failed++;
            $display("FAIL normal_state_load_prog: got %b, expected 1", state_load_prog);
        end
        send_word(32'h00000013, 0);
        send_word(32'h00100093, 1);
        send_byte(8'hB6, 0);
        tests_run++;
        if ({load_done, load_err, memcon_prog_ena} !== 3'b101) begin
            tests_failed++;
            $display("FAIL normal_done: got done/err/memcon=%b, expected 101",
                     {load_done, load_err, memcon_prog_ena});
        end
        @(negedge clk);
        tests_run++;
        if ({load_done, memcon_prog_ena} !== 2'b10) begin
            tests_failed++;
            $display("FAIL normal_release: got done/memcon=%b, expected 10",
                     {load_done, memcon_prog_ena});
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (memcon_prog_ena !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_no_restart: got memcon=%b with level held, expected 0", memcon_prog_ena);
        end
        tests_run++;
        if (wr_seen - wr0 != 2 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL normal_write_count: got %0d writes, %0d pending, expected 2 and 0",
                     wr_seen - wr0, exp_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        int wr0;
        wr0 = wr_seen;
        start_req();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h00000013, 0);
        send_word(32'h00100093, 1);
        send_byte(8'h00, 0);
        tests_run++;
        if ({load_done, load_err} !== 2'b01) begin
            tests_failed++;
            $display("FAIL badchk_flags: got done/err=%b, expected 01", {load_done, load_err});
        end
        @(negedge clk);
        tests_run++;
        if ({memcon_prog_ena, load_err} !== 2'b01) begin
            tests_failed++;
            $display("FAIL badchk_idle: got memcon/err=%b, expected 01", {memcon_prog_ena, load_err});
        end
        tests_run++;
        if (wr_seen - wr0 != 2) begin
            tests_failed++;
            $display("FAIL badchk_writes: got %0d, expected 2", wr_seen - wr0);
        end
    endtask

    task automatic test_junk_sync();
        int wr0;
        wr0 = wr_seen;
        start_req();
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h5A, 2);
        tests_run++;
        if ({memcon_prog_ena, state_load_prog, load_err} !== 3'b100) begin
            tests_failed++;
            $display("FAIL junk_held_sync: got memcon/slp/err=%b, expected 100",
                     {memcon_prog_ena, state_load_prog, load_err});
        end
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        send_word(32'hDEADBEEF, 0);
        send_byte(chk_acc, 0);
        tests_run++;
        if ({load_done, load_err} !== 2'b10 || wr_seen - wr0 != 1) begin
            tests_failed++;
            $display("FAIL junk_load: got done/err=%b writes=%0d, expected 10 and 1",
                     {load_done, load_err}, wr_seen - wr0);
        end
    endtask

    task automatic test_zero_len();
        int wr0;
        wr0 = wr_seen;
        start_req();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tests_run++;
        if (state_load_prog !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_len_check_state: got %b, expected 1", state_load_prog);
        end
        send_byte(8'h00, 0);
        tests_run++;
        if ({load_done, load_err} !== 2'b10 || wr_seen != wr0) begin
            tests_failed++;
            $display("FAIL zero_len_done: got done/err=%b writes=%0d, expected 10 and 0",
                     {load_done, load_err}, wr_seen - wr0);
        end
    endtask

    task automatic test_oversize();
        int wr0;
        wr0 = wr_seen;
        start_req();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        tests_run++;
        if ({load_err, load_done, state_load_prog} !== 3'b100) begin
            tests_failed++;
            $display("FAIL oversize_err: got err/done/slp=%b, expected 100",
                     {load_err, load_done, state_load_prog});
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (wr_seen != wr0 || memcon_prog_ena !== 1'b0) begin
            tests_failed++;
            $display("FAIL oversize_nowrite: got writes=%0d memcon=%b, expected 0 and 0",
                     wr_seen - wr0, memcon_prog_ena);
        end
    endtask

    task automatic test_timeout();
        int wr0;
        wr0 = wr_seen;
        start_req();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (99) @(negedge clk);
        tests_run++;
        if ({load_err, state_load_prog} !== 2'b01) begin
            tests_failed++;
            $display("FAIL timeout_early: got err/slp=%b at 99 cycles, expected 01",
                     {load_err, state_load_prog});
        end
        @(negedge clk);
        tests_run++;
        if (load_err !== 1'b1 || wr_seen != wr0) begin
            tests_failed++;
            $display("FAIL timeout_err: got err=%b writes=%0d at 100 cycles, expected 1 and 0",
                     load_err, wr_seen - wr0);
        end
    endtask

    task automatic test_async_reset();
        int wr0;
        wr0 = wr_seen;
        start_req();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        #2;
        Rst = 1'b1;
        #1;
        tests_run++;
        if ({memcon_prog_ena, state_load_prog, load_done, load_err} !== 4'b0000 ||
            ifc.imem_we !== 4'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got flags=%b we=%h, expected 0000 and 0",
                     {memcon_prog_ena, state_load_prog, load_done, load_err}, ifc.imem_we);
        end
        prog_req = 1'b0;
        repeat (2) @(negedge clk);
        Rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (wr_seen != wr0 || memcon_prog_ena !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_nowrite: got writes=%0d memcon=%b, expected 0 and 0",
                     wr_seen - wr0, memcon_prog_ena);
        end
        start_req();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFE0417, 0);
        send_byte(chk_acc, 0);
        tests_run++;
        if ({load_done, load_err} !== 2'b10 || wr_seen - wr0 != 1) begin
            tests_failed++;
            $display("FAIL async_reset_reload: got done/err=%b writes=%0d, expected 10 and 1",
                     {load_done, load_err}, wr_seen - wr0);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        wr_seen      = 0;
        cyc          = 0;
        chk_acc      = 8'h00;
        test_reset();
        test_normal_load();
        test_bad_checksum();
        test_junk_sync();
        test_zero_len();
        test_oversize();
        test_timeout();
        test_async_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL pending_writes: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
